// File: rtl/food_controller.sv
// Food controller: loads a snapshot of the generator's food map into a local
// 150-cell map, counts the food, then serves player eats and renderer reads
// through one arbitrated access port until the level is cleared.
module food_controller (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         gen_rst,
  input  logic         gen_busy,
  input  logic [299:0] gen_food,
  input  logic         eat_req,
  input  logic [7:0]   eat_cell,
  output logic         eat_ack,
  output logic [1:0]   eat_kind,
  input  logic         rd_req,
  input  logic [7:0]   rd_cell,
  output logic         rd_valid,
  output logic [1:0]   rd_data,
  output logic         ready,
  output logic [7:0]   food_left,
  output logic         level_clear
);

  typedef enum logic [2:0] {
    IDLE,
    GEN_RST,
    GEN_WAIT,
    LOAD,
    ACTIVE,
    CLEAR
  } state_t;

  localparam logic [7:0] NUM_CELLS = 8'd150;
  localparam logic [7:0] LAST_CELL = 8'd149;

  state_t       state;
  state_t       state_nxt;
  logic [299:0] food_map;
  logic [7:0]   scan_idx;
  logic         copied;
  logic         gen_cnt;
  logic         prio_eat;

  logic         eat_elig;
  logic         rd_elig;
  logic         eat_grant;
  logic         rd_grant;
  logic         eat_in_range;
  logic         rd_in_range;
  logic [8:0]   eat_bit;
  logic [8:0]   rd_bit;
  logic [8:0]   scan_bit;
  logic [1:0]   eat_prior;
  logic [1:0]   rd_prior;
  logic [1:0]   scan_cell;
  logic [7:0]   scan_count;
  logic         last_eat;

  // Arbitration and cell lookups; a requester whose ack/valid is showing this
  // cycle is treated as already served, so it cannot be granted twice.
  always_comb begin
    eat_bit      = {eat_cell, 1'b0};
    rd_bit       = {rd_cell, 1'b0};
    scan_bit     = {scan_idx, 1'b0};
    eat_in_range = (eat_cell < NUM_CELLS);
    rd_in_range  = (rd_cell < NUM_CELLS);
    eat_prior    = eat_in_range ? food_map[eat_bit +: 2] : 2'b00;
    rd_prior     = rd_in_range ? food_map[rd_bit +: 2] : 2'b00;
    scan_cell    = (scan_idx < NUM_CELLS) ? food_map[scan_bit +: 2] : 2'b00;
    scan_count   = food_left + {7'd0, (scan_cell != 2'b00)};
    eat_elig     = (state == ACTIVE) && eat_req && !eat_ack;
    rd_elig      = (state == ACTIVE) && rd_req && !rd_valid;
    eat_grant    = eat_elig && (!rd_elig || prio_eat);
    rd_grant     = rd_elig && !eat_grant;
    last_eat     = eat_grant && (eat_prior != 2'b00) && (food_left == 8'd1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; start aborts any level in progress.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = GEN_RST;
      GEN_RST:  if (gen_cnt) state_nxt = GEN_WAIT;
      GEN_WAIT: if (!gen_busy) state_nxt = LOAD;
      LOAD:     if (copied && scan_idx == LAST_CELL)
                  state_nxt = (scan_count == 8'd0) ? CLEAR : ACTIVE;
      ACTIVE:   if (last_eat) state_nxt = CLEAR;
      CLEAR:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (start && state != IDLE) state_nxt = GEN_RST;
  end

  // State-decoded outputs.
  always_comb begin
    gen_rst     = (state == GEN_RST);
    ready       = (state == ACTIVE);
    level_clear = (state == CLEAR);
  end

  // Datapath: map snapshot and scan during LOAD, eat/read service in ACTIVE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      food_map  <= '0;
      food_left <= 8'd0;
      scan_idx  <= 8'd0;
      copied    <= 1'b0;
      gen_cnt   <= 1'b0;
      prio_eat  <= 1'b1;
      eat_ack   <= 1'b0;
      eat_kind  <= 2'b00;
      rd_valid  <= 1'b0;
      rd_data   <= 2'b00;
    end else begin
      gen_cnt  <= (state == GEN_RST && !start) ? ~gen_cnt : 1'b0;
      copied   <= (state == LOAD);
      eat_ack  <= eat_grant;
      eat_kind <= eat_grant ? eat_prior : 2'b00;
      rd_valid <= rd_grant;
      rd_data  <= rd_grant ? rd_prior : 2'b00;
      if (state == LOAD) begin
        prio_eat <= 1'b1;
        if (!copied) begin
          food_map  <= gen_food;
          food_left <= 8'd0;
          scan_idx  <= 8'd0;
        end else begin
          food_left <= scan_count;
          scan_idx  <= scan_idx + 8'd1;
        end
      end else begin
        if (eat_grant) begin
          prio_eat <= 1'b0;
          if (eat_in_range) food_map[eat_bit +: 2] <= 2'b00;
          if (eat_prior != 2'b00) food_left <= food_left - 8'd1;
        end else if (rd_grant) begin
          prio_eat <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_food_controller.sv
// Directed bench for food_controller: level load, eat/read service,
// arbitration, out-of-range and empty eats, level clear, reset and abort.
module tb_food_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         gen_rst;
  logic         gen_busy;
  logic [299:0] gen_food;
  logic         eat_req;
  logic [7:0]   eat_cell;
  logic         eat_ack;
  logic [1:0]   eat_kind;
  logic         rd_req;
  logic [7:0]   rd_cell;
  logic         rd_valid;
  logic [1:0]   rd_data;
  logic         ready;
  logic [7:0]   food_left;
  logic         level_clear;

  int checks = 0;
  int errors = 0;
  int n;
  int fl;

  food_controller dut (
    .clk(clk), .rst(rst), .start(start), .gen_rst(gen_rst),
    .gen_busy(gen_busy), .gen_food(gen_food),
    .eat_req(eat_req), .eat_cell(eat_cell), .eat_ack(eat_ack), .eat_kind(eat_kind),
    .rd_req(rd_req), .rd_cell(rd_cell), .rd_valid(rd_valid), .rd_data(rd_data),
    .ready(ready), .food_left(food_left), .level_clear(level_clear)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Advance one clock edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic er, input logic [7:0] ec,
                               input logic rr, input logic [7:0] rc);
    eat_req  = er;
    eat_cell = ec;
    rd_req   = rr;
    rd_cell  = rc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Counts gen_rst-high cycles, starting at the first sample after start.
  task automatic countGenRst(output int cnt);
    cnt = 0;
    while (gen_rst === 1'b1 && cnt < 10) begin
      cnt++;
      tick();
    end
  endtask

  // Ticks until ready rises; the first tick only enters LOAD.
  task automatic waitReady(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (ready !== 1'b1 && cnt < 400);
    if (ready !== 1'b1) checkOutput("ready_timeout", 32'(ready), 32'd1);
  endtask

  function automatic logic [1:0] cellKind(input int c);
    if (c <= 9) return 2'b10;
    if (c <= 12) return 2'b11;
    if (c <= 132) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    for (int c = 0; c < 150; c++) gen_food[2*c +: 2] = cellKind(c);
    rst = 1'b0;
    start = 1'b0;
    gen_busy = 1'b1;
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    tick();
    tick();
    checkOutput("rst_gen_rst", 32'(gen_rst), 32'd0);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_food_left", 32'(food_left), 32'd0);
    checkOutput("rst_eat_ack", 32'(eat_ack), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_level_clear", 32'(level_clear), 32'd0);

    // Level load with gen_busy falling 5 cycles after gen_rst drops.
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    countGenRst(n);
    checkOutput("gen_rst_cycles", 32'(n), 32'd2);
    repeat (5) tick();
    checkOutput("wait_ready", 32'(ready), 32'd0);
    gen_busy = 1'b0;
    waitReady(n);
    checkOutput("load_cycles", 32'(n - 1), 32'd151);
    checkOutput("load_food_left", 32'(food_left), 32'd133);

    // Eat cell 7 (rare), then read it back and read a still-full cell.
    applyStimulus(1'b1, 8'd7, 1'b0, 8'd0);
    tick();
    checkOutput("eat7_ack", 32'(eat_ack), 32'd1);
    checkOutput("eat7_kind", 32'(eat_kind), 32'd2);
    checkOutput("eat7_food_left", 32'(food_left), 32'd132);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    tick();
    checkOutput("eat7_ack_drop", 32'(eat_ack), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b1, 8'd7);
    tick();
    checkOutput("rd7_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd7_data", 32'(rd_data), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b1, 8'd0);
    tick();
    tick();
    checkOutput("rd0_valid", 32'(rd_valid), 32'd1);
    checkOutput("rd0_data", 32'(rd_data), 32'd2);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    tick();

    // Both requests held: grants alternate eat, rd, eat, rd.
    applyStimulus(1'b1, 8'd0, 1'b1, 8'd10);
    for (int g = 0; g < 4; g++) begin
      tick();
      checkOutput($sformatf("arb%0d_eat_ack", g), 32'(eat_ack), 32'(g % 2 == 0));
      checkOutput($sformatf("arb%0d_rd_valid", g), 32'(rd_valid), 32'(g % 2 == 1));
      if (g == 0) checkOutput("arb0_kind", 32'(eat_kind), 32'd2);
      if (g == 2) checkOutput("arb2_kind", 32'(eat_kind), 32'd0);
      if (g % 2 == 1) checkOutput($sformatf("arb%0d_rd_data", g), 32'(rd_data), 32'd3);
    end
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    tick();
    checkOutput("arb_food_left", 32'(food_left), 32'd131);

    // Out-of-range and empty eats change nothing.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, (k == 0) ? 8'd150 : (k == 1) ? 8'd255 : 8'd140, 1'b0, 8'd0);
      tick();
      checkOutput($sformatf("null%0d_ack", k), 32'(eat_ack), 32'd1);
      checkOutput($sformatf("null%0d_kind", k), 32'(eat_kind), 32'd0);
      applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
      tick();
    end
    checkOutput("null_food_left", 32'(food_left), 32'd131);
    applyStimulus(1'b0, 8'd0, 1'b1, 8'd200);
    tick();
    checkOutput("rd200_data", 32'(rd_data), 32'd0);
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    tick();

    // Eat all remaining food; the last eat raises level_clear with its ack.
    fl = 131;
    for (int c = 1; c <= 132; c++) begin
      if (c != 7) begin
        applyStimulus(1'b1, 8'(c), 1'b0, 8'd0);
        tick();
        fl--;
        checkOutput($sformatf("clr%0d_ack", c), 32'(eat_ack), 32'd1);
        checkOutput($sformatf("clr%0d_kind", c), 32'(eat_kind), 32'(cellKind(c)));
        checkOutput($sformatf("clr%0d_food_left", c), 32'(food_left), 32'(fl));
        checkOutput($sformatf("clr%0d_level_clear", c), 32'(level_clear), 32'(fl == 0));
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
        tick();
        checkOutput($sformatf("clr%0d_ack_drop", c), 32'(eat_ack), 32'd0);
      end
    end
    checkOutput("idle_ready", 32'(ready), 32'd0);
    checkOutput("idle_level_clear", 32'(level_clear), 32'd0);
    checkOutput("idle_food_left", 32'(food_left), 32'd0);

    // Reset in the middle of LOAD (after 60 cells scanned), start held too.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    repeat (60) tick();
    checkOutput("midload_food_left", 32'(food_left), 32'd60);
    checkOutput("midload_ready", 32'(ready), 32'd0);
    rst = 1'b0;
    start = 1'b1;
    applyStimulus(1'b1, 8'd20, 1'b1, 8'd20);
    tick();
    checkOutput("mrst_gen_rst", 32'(gen_rst), 32'd0);
    checkOutput("mrst_food_left", 32'(food_left), 32'd0);
    checkOutput("mrst_ready", 32'(ready), 32'd0);
    checkOutput("mrst_eat_ack", 32'(eat_ack), 32'd0);
    checkOutput("mrst_rd_valid", 32'(rd_valid), 32'd0);
    start = 1'b0;
    applyStimulus(1'b0, 8'd0, 1'b0, 8'd0);
    rst = 1'b1;
    tick();
    checkOutput("post_rst_idle", 32'(gen_rst), 32'd0);

    // Restart, reach ACTIVE, then abort mid-ACTIVE with start.
    start = 1'b1;
    tick();
    start = 1'b0;
    countGenRst(n);
    checkOutput("restart_gen_rst_cycles", 32'(n), 32'd2);
    waitReady(n);
    checkOutput("restart_load_cycles", 32'(n - 1), 32'd151);
    checkOutput("restart_food_left", 32'(food_left), 32'd133);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("abort_ready", 32'(ready), 32'd0);
    countGenRst(n);
    checkOutput("abort_gen_rst_cycles", 32'(n), 32'd2);
    tick();
    tick();
    checkOutput("abort_recount_zero", 32'(food_left), 32'd0);
    waitReady(n);
    checkOutput("abort_food_left", 32'(food_left), 32'd133);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/food_controller.md
FOOD_CONTROLLER -- requirements
Module: food_controller

Interface
REQ-001 clk  in  1  single system clock; all state updates on the rising edge.
REQ-002 rst  in  1  reset; synchronous, active-low (rst=0 sampled at a clk edge resets the block).
REQ-003 start  in  1  one-cycle pulse; begins a new level.
REQ-004 gen_rst  out  1  active-high reset to the food generator.
REQ-005 gen_busy  in  1  generator busy flag; high while the generator is filling its map.
REQ-006 gen_food  in  300  generator map; cell c (0..149) is bits [2c+1:2c].
REQ-007 eat_req  in  1  player eat request; held high until eat_ack.
REQ-008 eat_cell  in  8  cell index for eat_req; held stable while eat_req is high.
REQ-009 eat_ack  out  1  one-cycle acknowledge of eat_req.
REQ-010 eat_kind  out  2  prior cell contents; valid while eat_ack is high.
REQ-011 rd_req  in  1  renderer read request; held high until rd_valid.
REQ-012 rd_cell  in  8  cell index for rd_req; held stable while rd_req is high.
REQ-013 rd_valid  out  1  one-cycle read-data strobe.
REQ-014 rd_data  out  2  cell contents; valid while rd_valid is high.
REQ-015 ready  out  1  high only in ACTIVE.
REQ-016 food_left  out  8  count of non-empty cells in the local map.
REQ-017 level_clear  out  1  one-cycle pulse when the last food item is eaten.

Function
REQ-018 Cell encoding SHALL be: 00 empty, 01 normal, 10 rare, 11 crux.
REQ-019 The block SHALL hold a local 150x2-bit map; the generator map SHALL be read only during LOAD.
REQ-020 FSM states SHALL be IDLE, GEN_RST, GEN_WAIT, LOAD, ACTIVE, CLEAR.
REQ-021 IDLE: on start -> GEN_RST.
REQ-022 GEN_RST: gen_rst=1 for exactly 2 cycles, then -> GEN_WAIT.
REQ-023 GEN_WAIT: on gen_busy=0 -> LOAD.
REQ-024 LOAD: entry copies gen_food into the local map and clears food_left and the scan index.
REQ-025 LOAD: the block SHALL scan one cell per cycle (index 0..149), incrementing food_left for each non-empty cell; after cell 149 -> ACTIVE (151 cycles in LOAD).
REQ-026 ACTIVE: the map SHALL have a single access port and grant at most one request per cycle.
REQ-027 Arbitration when only one request is pending: grant that request.
REQ-028 Arbitration when both requests are pending: grant the requester not granted most recently; eat wins the first conflict after LOAD.
REQ-029 Eat grant, edge N: the addressed cell is cleared to 00; food_left decrements if the cell was non-zero.
REQ-030 Eat grant, cycle N+1: eat_ack=1 and eat_kind = prior contents.
REQ-031 Read grant, edge N: the map is not modified; cycle N+1: rd_valid=1 and rd_data = cell contents.
REQ-032 A requester SHALL not be re-granted in the cycle its ack/valid is high; the request is treated as consumed.
REQ-033 Index >=150: eat is acked with eat_kind=00 and no change; read returns rd_data=00.
REQ-034 Eat of an empty cell: acked with eat_kind=00; food_left unchanged.
REQ-035 When an eat takes food_left from 1 to 0 -> CLEAR.
REQ-036 CLEAR: level_clear=1 for one cycle (the same cycle as the final eat_ack), then -> IDLE.
REQ-037 Outside ACTIVE, requests SHALL be held off: no ack, no valid, and nothing granted.
REQ-038 If LOAD finishes with food_left=0 -> CLEAR directly.
REQ-039 start in any non-IDLE state SHALL abort and go to GEN_RST; an in-flight ack/valid still completes in the following cycle.
REQ-040 In all states other than GEN_RST, gen_rst=0.

Reset
REQ-041 rst=0 SHALL force state IDLE, food_left=0, local map all 00, and the conflict-priority flag to eat.
REQ-042 rst=0 SHALL force eat_ack, eat_kind, rd_valid, rd_data, ready, level_clear and gen_rst to 0.
REQ-043 Reset SHALL take priority over start and over any request, including mid-LOAD and mid-handshake.

Verification
REQ-044 Scenario: start; gen_busy falls 5 cycles after gen_rst drops; gen_food has 120 cells =01, 10 =10, 3 =11 -> gen_rst high 2 cycles; ready after 151 LOAD cycles; food_left=133.
REQ-045 Scenario: ACTIVE; eat cell 7 (=10) -> eat_ack next cycle, eat_kind=10, food_left 133->132; read cell 7 -> rd_data=00.
REQ-046 Scenario: eat_req and rd_req both held high for 4 grants -> grants alternate eat, rd, eat, rd; no cycle has both eat_ack and rd_valid.
REQ-047 Scenario: eat cells 150 and 255, plus an empty cell -> all acked with eat_kind=00; food_left unchanged.
REQ-048 Scenario: eat the last food item -> eat_ack and level_clear in the same cycle; food_left=0; IDLE next cycle; ready=0.
REQ-049 Scenario: rst=0 at LOAD index 60, then start mid-ACTIVE -> after reset all outputs=0 and state IDLE; the restart gives 2 gen_rst cycles and food_left recounted from 0.
